// File: rtl/video_ctrl_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : video_ctrl_sequencer_if
// Brief    : Request/response bundle between control sources and the sequencer
// Revision : 1.0
// ============================================================================
interface video_ctrl_sequencer_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [7:0]  cpu_op;
  logic [31:0] cpu_data;

  logic        bulk_valid;
  logic        bulk_ready;
  logic [7:0]  bulk_op;
  logic [31:0] bulk_data;

  logic        ms_start;
  logic        ms_busy;
  logic        ms_done;
  logic [11:0] ms_width;
  logic [11:0] ms_height;
  logic [11:0] ms_letterbox;
  logic [15:0] ms_h_max;
  logic [15:0] ms_v_max;
  logic [15:0] ms_hs_start;
  logic [15:0] ms_hs_end;
  logic [15:0] ms_vs_start;
  logic [15:0] ms_vs_end;
  logic        ms_polarity;
  logic [1:0]  ms_scale;
  logic [2:0]  ms_colormode;

  logic [7:0]  control_op;
  logic [31:0] control_data;
  logic        idle;

  // Sequencer side
  modport master (
    input  cpu_valid, cpu_op, cpu_data,
    output cpu_ready,
    input  bulk_valid, bulk_op, bulk_data,
    output bulk_ready,
    input  ms_start, ms_width, ms_height, ms_letterbox, ms_h_max, ms_v_max,
           ms_hs_start, ms_hs_end, ms_vs_start, ms_vs_end, ms_polarity,
           ms_scale, ms_colormode,
    output ms_busy, ms_done,
    output control_op, control_data, idle
  );

  // Requester / formatter side
  modport slave (
    output cpu_valid, cpu_op, cpu_data,
    input  cpu_ready,
    output bulk_valid, bulk_op, bulk_data,
    input  bulk_ready,
    output ms_start, ms_width, ms_height, ms_letterbox, ms_h_max, ms_v_max,
           ms_hs_start, ms_hs_end, ms_vs_start, ms_vs_end, ms_polarity,
           ms_scale, ms_colormode,
    input  ms_busy, ms_done,
    input  control_op, control_data, idle
  );
endinterface
`default_nettype wire

// File: rtl/video_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : video_ctrl_sequencer
// Brief    : Arbitrates CPU, bulk and atomic mode-set ops onto the control bus
// Revision : 1.0
// ============================================================================
module video_ctrl_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                          m_axis_vid_aclk,
  input  logic                          aresetn,
  video_ctrl_sequencer_if.master        bus
);

  localparam logic [7:0] c_HOLD_LOAD   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] c_GAP_LOAD    = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] c_MS_OPS      = 4'd9;

  localparam logic [7:0] c_OP_COLORMODE  = 8'd1;
  localparam logic [7:0] c_OP_DIMENSIONS = 8'd2;
  localparam logic [7:0] c_OP_SCALE      = 8'd4;
  localparam logic [7:0] c_OP_VSYNC      = 8'd5;
  localparam logic [7:0] c_OP_MAX        = 8'd6;
  localparam logic [7:0] c_OP_HS         = 8'd7;
  localparam logic [7:0] c_OP_VS         = 8'd8;
  localparam logic [7:0] c_OP_POLARITY   = 8'd10;
  localparam logic [7:0] c_OP_LETTERBOX  = 8'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_rr_last;        // 1 = bulk served last
  logic        r_ms_busy;
  logic        r_ms_done;
  logic [3:0]  r_step;
  logic [7:0]  r_control_op;
  logic [31:0] r_control_data;

  logic [11:0] r_ms_width;
  logic [11:0] r_ms_height;
  logic [11:0] r_ms_letterbox;
  logic [15:0] r_ms_h_max;
  logic [15:0] r_ms_v_max;
  logic [15:0] r_ms_hs_start;
  logic [15:0] r_ms_hs_end;
  logic [15:0] r_ms_vs_start;
  logic [15:0] r_ms_vs_end;
  logic        r_ms_polarity;
  logic [1:0]  r_ms_scale;
  logic [2:0]  r_ms_colormode;

  logic        w_slot;
  logic        w_cpu_win;
  logic        w_bulk_win;
  logic        w_cpu_fire;
  logic        w_bulk_fire;
  logic        w_load;
  logic [7:0]  w_load_op;
  logic [31:0] w_load_data;
  logic [7:0]  w_ms_op;
  logic [31:0] w_ms_data;
  logic        w_seq_end;

  // A pending mode-set blocks both requesters out of every IDLE slot.
  assign w_slot      = (r_state == ST_IDLE) && !r_ms_busy;
  assign w_cpu_fire  = aresetn && w_slot && w_cpu_win;
  assign w_bulk_fire = aresetn && w_slot && w_bulk_win;
  assign w_seq_end   = (r_state == ST_GAP) && (r_cnt == 8'd0) && r_ms_busy &&
                       (r_step == c_MS_OPS);

  always_comb begin
    w_cpu_win  = 1'b0;
    w_bulk_win = 1'b0;
    if (bus.cpu_valid && bus.bulk_valid) begin
      w_cpu_win  = r_rr_last;
      w_bulk_win = !r_rr_last;
    end else begin
      w_cpu_win  = bus.cpu_valid;
      w_bulk_win = bus.bulk_valid;
    end
  end

  always_comb begin
    w_ms_op   = 8'd0;
    w_ms_data = 32'd0;
    case (r_step)
      4'd0: begin w_ms_op = c_OP_DIMENSIONS; w_ms_data = {4'b0, r_ms_height, 4'b0, r_ms_width}; end
      4'd1: begin w_ms_op = c_OP_MAX;        w_ms_data = {r_ms_v_max, r_ms_h_max};               end
      4'd2: begin w_ms_op = c_OP_HS;         w_ms_data = {r_ms_hs_start, r_ms_hs_end};           end
      4'd3: begin w_ms_op = c_OP_VS;         w_ms_data = {r_ms_vs_start, r_ms_vs_end};           end
      4'd4: begin w_ms_op = c_OP_POLARITY;   w_ms_data = {31'b0, r_ms_polarity};                 end
      4'd5: begin w_ms_op = c_OP_SCALE;      w_ms_data = {30'b0, r_ms_scale};                    end
      4'd6: begin w_ms_op = c_OP_COLORMODE;  w_ms_data = {29'b0, r_ms_colormode};                end
      4'd7: begin w_ms_op = c_OP_LETTERBOX;  w_ms_data = {20'b0, r_ms_letterbox};                end
      4'd8: begin w_ms_op = c_OP_VSYNC;      w_ms_data = 32'd0;                                  end
      default: begin w_ms_op = 8'd0;         w_ms_data = 32'd0;                                  end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_load_op   = 8'd0;
    w_load_data = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (r_ms_busy) begin
          w_load      = 1'b1;
          w_load_op   = w_ms_op;
          w_load_data = w_ms_data;
        end else if (w_cpu_fire && (bus.cpu_op != 8'd0)) begin
          w_load      = 1'b1;
          w_load_op   = bus.cpu_op;
          w_load_data = bus.cpu_data;
        end else if (w_bulk_fire && (bus.bulk_op != 8'd0)) begin
          w_load      = 1'b1;
          w_load_op   = bus.bulk_op;
          w_load_data = bus.bulk_data;
        end
        if (w_load) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = c_GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'd0;
      r_rr_last      <= 1'b1;
      r_ms_busy      <= 1'b0;
      r_ms_done      <= 1'b0;
      r_step         <= 4'd0;
      r_control_op   <= 8'd0;
      r_control_data <= 32'd0;
      r_ms_width     <= 12'd0;
      r_ms_height    <= 12'd0;
      r_ms_letterbox <= 12'd0;
      r_ms_h_max     <= 16'd0;
      r_ms_v_max     <= 16'd0;
      r_ms_hs_start  <= 16'd0;
      r_ms_hs_end    <= 16'd0;
      r_ms_vs_start  <= 16'd0;
      r_ms_vs_end    <= 16'd0;
      r_ms_polarity  <= 1'b0;
      r_ms_scale     <= 2'd0;
      r_ms_colormode <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ms_done <= w_seq_end;

      // Data only moves on HOLD entry; the op drops to NOP on GAP entry.
      if (w_load) begin
        r_control_op   <= w_load_op;
        r_control_data <= w_load_data;
      end else if ((r_state == ST_HOLD) && (w_state_nxt == ST_GAP)) begin
        r_control_op <= 8'd0;
      end

      if (w_cpu_fire) begin
        r_rr_last <= 1'b0;
      end else if (w_bulk_fire) begin
        r_rr_last <= 1'b1;
      end

      if (w_seq_end) begin
        r_ms_busy <= 1'b0;
        r_step    <= 4'd0;
      end else if (!r_ms_busy && bus.ms_start) begin
        r_ms_busy      <= 1'b1;
        r_ms_width     <= bus.ms_width;
        r_ms_height    <= bus.ms_height;
        r_ms_letterbox <= bus.ms_letterbox;
        r_ms_h_max     <= bus.ms_h_max;
        r_ms_v_max     <= bus.ms_v_max;
        r_ms_hs_start  <= bus.ms_hs_start;
        r_ms_hs_end    <= bus.ms_hs_end;
        r_ms_vs_start  <= bus.ms_vs_start;
        r_ms_vs_end    <= bus.ms_vs_end;
        r_ms_polarity  <= bus.ms_polarity;
        r_ms_scale     <= bus.ms_scale;
        r_ms_colormode <= bus.ms_colormode;
      end else if (w_load && r_ms_busy) begin
        r_step <= r_step + 4'd1;
      end
    end
  end

  assign bus.cpu_ready    = w_cpu_fire;
  assign bus.bulk_ready   = w_bulk_fire;
  assign bus.ms_busy      = r_ms_busy;
  assign bus.ms_done      = r_ms_done;
  assign bus.control_op   = r_control_op;
  assign bus.control_data = r_control_data;
  assign bus.idle         = (r_state == ST_IDLE) && !r_ms_busy;

endmodule
`default_nettype wire
